// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss/fill sequencer.
package cache_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_BITS = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STORE,
        DONE
    } fsm_state_t;

    // Clears the word offset and the byte-in-word bit so the block base is aligned.
    function automatic logic [31:0] block_base(input logic [31:0] addr, input int offset_bits);
        return addr & ~((32'd1 << (offset_bits + 1)) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_fill_lat_pipe.sv
// Delay line matching the memory read latency: carries {valid, word index} of each issued read.
// LAT=0 is a combinational pass-through; otherwise LAT registered stages, flushed by rst.
module fill_lat_pipe #(
    parameter int LAT = 0,
    parameter int IW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_vld,
    input  logic [IW-1:0] issue_idx,
    output logic          ret_vld,
    output logic [IW-1:0] ret_idx
);

    generate
        if (LAT == 0) begin : g_bypass
            logic pipe_unused;
            assign pipe_unused = clk ^ rst;
            assign ret_vld     = issue_vld;
            assign ret_idx     = issue_idx;
        end else begin : g_stages
            logic [LAT-1:0] vld_q;
            logic [IW-1:0]  idx_q [LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < LAT; s++) begin
                        vld_q[s] <= 1'b0;
                        idx_q[s] <= '0;
                    end
                end else begin
                    vld_q[0] <= issue_vld;
                    idx_q[0] <= issue_idx;
                    for (int s = 1; s < LAT; s++) begin
                        vld_q[s] <= vld_q[s-1];
                        idx_q[s] <= idx_q[s-1];
                    end
                end
            end

            assign ret_vld = vld_q[LAT-1];
            assign ret_idx = idx_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss/fill sequencer: streams a cache block from memory one read per cycle, plus write-through stores.
// Optional CACHE_CRITICAL_WORD_FIRST_EN starts the fill at the missed word and wraps within the block.
module cache_fill_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    parameter int MEM_LAT     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_req,
    input  logic [ADDR_WIDTH-1:0]          miss_addr,
    input  logic                           store_req,
    input  logic [ADDR_WIDTH-1:0]          store_addr,
    input  logic [15:0]                    store_data,
    output logic                           busy,
    output logic                           fill_we,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic [15:0]                    fill_data,
    output logic                           fill_done,
    output logic                           store_done,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_rdata
);

    import cache_pkg::*;

    localparam int OFF_W    = $clog2(BLOCK_WORDS);
    localparam int FILL_CYC = BLOCK_WORDS + MEM_LAT;
    localparam int CW       = $clog2(FILL_CYC + 1);

    fsm_state_t             state;
    fsm_state_t             state_nxt;
    logic [CW-1:0]          cnt;
    logic [ADDR_WIDTH-1:0]  base;
    logic [OFF_W-1:0]       start;
    logic [OFF_W-1:0]       first_idx;
    logic [OFF_W-1:0]       issue_idx;
    logic                   issue;
    logic                   ret_vld;
    logic [OFF_W-1:0]       ret_idx;
    logic                   store_addr_unused;

    assign store_addr_unused = store_addr[0];

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign first_idx = miss_addr[OFF_W:1];
`else
    assign first_idx = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (miss_req) begin
                    state_nxt = FILL;
                end else if (store_req) begin
                    state_nxt = STORE;
                end
            end
            FILL:    if (cnt == CW'(FILL_CYC - 1)) state_nxt = DONE;
            STORE:   state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address and start offset are captured only on acceptance; the requester may change them afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            base  <= '0;
            start <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (miss_req) begin
                base  <= ADDR_WIDTH'(block_base(32'(miss_addr), OFF_W));
                start <= first_idx;
            end
        end else if (state == FILL) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign issue     = (state == FILL) && (cnt < CW'(BLOCK_WORDS));
    assign issue_idx = start + cnt[OFF_W-1:0];

    fill_lat_pipe #(
        .LAT (MEM_LAT),
        .IW  (OFF_W)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .issue_vld (issue),
        .issue_idx (issue_idx),
        .ret_vld   (ret_vld),
        .ret_idx   (ret_idx)
    );

    always_comb begin
        busy          = (state != IDLE);
        fill_we       = 1'b0;
        fill_word_idx = '0;
        fill_data     = '0;
        fill_done     = 1'b0;
        store_done    = 1'b0;
        mem_addr      = '0;
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_wdata     = '0;
        case (state)
            FILL: begin
                if (issue) begin
                    mem_en   = 1'b1;
                    mem_addr = base | ADDR_WIDTH'({issue_idx, 1'b0});
                end
                if (ret_vld) begin
                    fill_we       = 1'b1;
                    fill_word_idx = ret_idx;
                    fill_data     = mem_rdata;
                end
            end
            STORE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = {store_addr[ADDR_WIDTH-1:1], 1'b0};
                mem_wdata  = store_data;
                store_done = 1'b1;
            end
            DONE:    fill_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Miss/fill sequencer between the L1 cache data array and the 16-bit byte-addressable main memory.
- On a cache miss it streams BLOCK_WORDS consecutive words from memory into the cache data array, one read issued per cycle.
- It also performs single-word write-through stores.
- It is the only master of the memory port; reads and writes never overlap.

Parameters:
- ADDR_WIDTH, 16, byte-address width of memory and requests.
- BLOCK_WORDS, 8, 16-bit words per cache block; power of 2, ≥2.
- MEM_LAT, 0, cycles from read issue to read data valid on mem_rdata. 0 means combinational: data is sampled in the issue cycle.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- miss_req, in, 1, level; requester holds it until fill_done.
- miss_addr, in, ADDR_WIDTH, byte address of the missing access.
- store_req, in, 1, level; requester holds it until store_done.
- store_addr, in, ADDR_WIDTH, store byte address; bit0 ignored.
- store_data, in, 16, store data.
- busy, out, 1, high in any state other than IDLE.
- fill_we, out, 1, write strobe into the cache data array.
- fill_word_idx, out, log2(BLOCK_WORDS), word offset inside the block.
- fill_data, out, 16, word to write into the cache.
- fill_done, out, 1, one-cycle pulse after the last fill word.
- store_done, out, 1, one-cycle pulse when the store completes.
- mem_addr, out, ADDR_WIDTH, memory byte address; bit0 always 0.
- mem_en, out, 1, memory enable.
- mem_wr, out, 1, memory write.
- mem_wdata, out, 16, memory write data.
- mem_rdata, in, 16, memory read data.

Behaviour:
- Reset: rst is synchronous, active-high, on clk. All outputs are 0, FSM goes to IDLE, counters clear, latency pipe flushes.
- States:
  - IDLE: miss_req → FILL; else store_req → STORE. miss has priority when both are high.
  - FILL: runs the read sequence below, then → DONE.
  - STORE: single-cycle write-through, then → IDLE.
  - DONE: one cycle with fill_done=1, then → IDLE.
- On entering FILL:
  - base = miss_addr with the low log2(BLOCK_WORDS)+1 bits cleared.
  - Issue counter i = 0..BLOCK_WORDS-1.
  - Each cycle: mem_en=1, mem_wr=0, mem_addr = base + 2*i.
- Return path:
  - Each issued index enters a MEM_LAT-deep valid/index delay line.
  - On exit: fill_we=1, fill_word_idx = that index, fill_data = mem_rdata.
  - After the last issue and until the pipe drains: mem_en=0.
- FILL length is BLOCK_WORDS+MEM_LAT cycles. fill_done is asserted in the cycle after the last fill_we (the DONE state).
- STORE: one cycle with mem_en=1, mem_wr=1, mem_addr={store_addr[ADDR_WIDTH-1:1],1'b0}, mem_wdata=store_data, and store_done=1.
- A request that arrives while busy is ignored until IDLE. Because requests are level-held, a held request is accepted on the first IDLE cycle.
- Block base is aligned, so address generation never wraps past the end of the block. Top block (0xFFF0 with defaults) ends at 0xFFFE.
- mem_rdata is ignored whenever no delay-line slot exits.
- rst mid-FILL: abort immediately. No further fill_we, no fill_done; the partial block stays invalid in the cache (the cache owns the valid bit).
- miss_addr is sampled only on the IDLE→FILL transition; later changes have no effect.
- When mem_en=0, mem_addr, mem_wr and mem_wdata are 0.

Optional Feature:
CACHE_CRITICAL_WORD_FIRST_EN
- Defined: the fill starts at the missed word k = miss_addr[log2(BLOCK_WORDS):1] and proceeds k, k+1, …, wrapping modulo BLOCK_WORDS. fill_word_idx reports the true offset.
- Undefined: the fill always starts at offset 0. Cycle count is identical either way.

Decomposition:
- Package cache_pkg holds:
  - BLOCK_WORDS and OFFSET_BITS=$clog2(BLOCK_WORDS).
  - fsm_state_t enum {IDLE, FILL, STORE, DONE}.
  - Helper function block_base(addr).
- Sub-module fill_lat_pipe: MEM_LAT-deep shift register of {valid, idx}. MEM_LAT=0 is a pass-through.

Test Plan:
- Reset, then miss_req=1 with miss_addr=0x1236 and MEM_LAT=0 → mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles; fill_we each cycle with idx 0..7 and fill_data = memory contents; fill_done on cycle 9.
- MEM_LAT=3, same miss → first fill_we 3 cycles after the first issue; 8 strobes total; fill_done 12 cycles after acceptance; mem_en low during the 3-cycle drain.
- miss_req and store_req rising together → fill completes first, then a single write cycle at store_addr with store_done; memory word updated, fill data unaffected.
- store_req with store_addr=0x0041 and store_data=0xBEEF → mem_addr=0x0040, mem_wr=1 for one cycle; a subsequent fill of block 0x0040 returns idx0 = 0xBEEF.
- rst asserted on the 4th fill cycle → next cycle all outputs 0, no fill_done; a new miss restarts from idx 0.
- With CACHE_CRITICAL_WORD_FIRST_EN and miss_addr=0x123A → fill_word_idx order 5,6,7,0,1,2,3,4, with mem_addr order matching.
